mux_select_bank: RTL and testbench
==================================

MUX_SELECT_BANK -- requirements
Module: mux_select_bank

Interface
REQ-001 Parameter: BUS_W, default 8, data width of the bus multiplexer.
REQ-002 The design SHALL use one clock and an asynchronous, active-high reset.
REQ-003 Port: clk  input  1  rising-edge clock for all output registers.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: i_a  input  1  2:1 mux data input, selected when select=0.
REQ-006 Port: i_b  input  1  2:1 mux data input, selected when select=1.
REQ-007 Port: select  input  1  2:1 mux select.
REQ-008 Port: o_data  output  1  2:1 mux result, combinational.
REQ-009 Port: o_data_q  output  1  2:1 mux result, registered.
REQ-010 Port: a, b, c, d  input  1 each  4:1 bit-mux data inputs, selected by sel4 = 00, 01, 10, 11.
REQ-011 Port: sel4  input  2  4:1 bit-mux select.
REQ-012 Port: out4  output  1  4:1 bit-mux result, combinational.
REQ-013 Port: out4_q  output  1  4:1 bit-mux result, registered.
REQ-014 Port: bus_a, bus_b, bus_c, bus_d  input  BUS_W each  bus-mux data inputs, selected by bus_sel = 00, 01, 10, 11.
REQ-015 Port: bus_sel  input  2  bus-mux select.
REQ-016 Port: bus_out  output  BUS_W  bus-mux result, combinational.
REQ-017 Port: bus_out_q  output  BUS_W  bus-mux result, registered.

Function
REQ-018 o_data SHALL equal i_a when select=0 and i_b when select=1, with zero latency.
REQ-019 out4 SHALL equal a/b/c/d for sel4 = 00/01/10/11, with zero latency.
REQ-020 bus_out SHALL equal bus_a/bus_b/bus_c/bus_d for bus_sel = 00/01/10/11, with zero latency and full BUS_W width (no truncation or extension).
REQ-021 Any X/Z on a select SHALL drive the corresponding combinational output to all zeros (full case with a default branch; no latches).
REQ-022 Each *_q output SHALL capture its combinational counterpart on every rising clk edge while rst=0 (latency of exactly 1 cycle, no enable).
REQ-023 Select and data changes between clock edges SHALL affect combinational outputs immediately and registered outputs only at the next edge.
REQ-024 The three multiplexers SHALL be fully independent; a select on one SHALL never affect another.

Reset
REQ-025 When rst is asserted, o_data_q, out4_q and bus_out_q SHALL go to 0 immediately, without waiting for clk.
REQ-026 While rst is held, the registered outputs SHALL stay 0; combinational outputs SHALL continue to follow their inputs.
REQ-027 After rst deasserts, the first rising clk edge SHALL load the current mux results.

Structure
REQ-028 The select encodings (SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_D=2'b11) and the default BUS_W SHALL reside in the shared package mux_pkg.
REQ-029 A parameterised sub-module mux4 (WIDTH, four inputs, 2-bit select) SHALL be instantiated twice: WIDTH=1 for the bit mux and WIDTH=BUS_W for the bus mux.
REQ-030 The 2:1 mux SHALL be implemented inline.

Verification
REQ-031 i_a=0, i_b=1, select=0 -> o_data=0; after one clk edge, o_data_q=0. Then select=1 -> o_data=1 immediately, and o_data_q=1 after the next edge.
REQ-032 a=0, b=1, c=0, d=0, sel4=01 -> out4=1; sweep sel4 through 00/10/11 with a single 1 walked across a..d -> out4 is 1 only when the selected input is 1.
REQ-033 bus_a=8'h01, bus_b=8'h02, bus_c=8'h03, bus_d=8'h04: bus_sel=00 -> bus_out=8'h01; 01 -> 8'h02; 10 -> 8'h03; 11 -> 8'h04; each bus_out_q matches one cycle later.
REQ-034 Assert rst mid-cycle with bus_out_q=8'h04 -> bus_out_q=8'h00 before the next clk edge; deassert rst -> 8'h04 at the following edge.
REQ-035 bus_sel=2'bxx -> bus_out=8'h00.
REQ-036 Change select alone while sel4 and bus_sel are held -> out4 and bus_out remain unchanged.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the select-bank multiplexers: select encodings
// and the default bus width.
package mux_pkg;

  localparam int BUS_W_DEFAULT = 8;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

endpackage : mux_pkg

// File: rtl/mux4.sv
// Parameterised 4:1 multiplexer. A select carrying X/Z falls through to
// the default branch and drives all zeros rather than propagating garbage.
module mux4
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [WIDTH-1:0] in_d,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y
);

  // Pick one of four inputs; unknown selects resolve to zero.
  always_comb begin
    // NOTE: assigning a default before the case guarantees every path
    // writes y, so no latch can be inferred even if a branch is dropped.
    y = '0;
    case (sel)
      SEL_A:   y = in_a;
      SEL_B:   y = in_b;
      SEL_C:   y = in_c;
      SEL_D:   y = in_d;
      default: y = '0;
    endcase
  end

endmodule : mux4

// File: rtl/mux_select_bank.sv
// Bank of three independent multiplexers (2:1 bit, 4:1 bit, 4:1 bus),
// each with a combinational output and a one-cycle registered copy.
module mux_select_bank
  import mux_pkg::*;
#(
  parameter int BUS_W = BUS_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  // 2:1 mux
  input  logic             i_a,
  input  logic             i_b,
  input  logic             select,
  output logic             o_data,
  output logic             o_data_q,
  // 4:1 bit mux
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic [1:0]       sel4,
  output logic             out4,
  output logic             out4_q,
  // 4:1 bus mux
  input  logic [BUS_W-1:0] bus_a,
  input  logic [BUS_W-1:0] bus_b,
  input  logic [BUS_W-1:0] bus_c,
  input  logic [BUS_W-1:0] bus_d,
  input  logic [1:0]       bus_sel,
  output logic [BUS_W-1:0] bus_out,
  output logic [BUS_W-1:0] bus_out_q
);

  // Inline 2:1 mux; an unknown select drives zero.
  always_comb begin
    o_data = 1'b0;
    case (select)
      1'b0:    o_data = i_a;
      1'b1:    o_data = i_b;
      default: o_data = 1'b0;
    endcase
  end

  mux4 #(.WIDTH(1)) u_bit_mux (
    .in_a (a),
    .in_b (b),
    .in_c (c),
    .in_d (d),
    .sel  (sel4),
    .y    (out4)
  );

  mux4 #(.WIDTH(BUS_W)) u_bus_mux (
    .in_a (bus_a),
    .in_b (bus_b),
    .in_c (bus_c),
    .in_d (bus_d),
    .sel  (bus_sel),
    .y    (bus_out)
  );

  // Register every combinational result each cycle; reset clears at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_data_q  <= 1'b0;
      out4_q    <= 1'b0;
      bus_out_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all three registers sampling
      // pre-edge values, independent of statement order.
      o_data_q  <= o_data;
      out4_q    <= out4;
      bus_out_q <= bus_out;
    end
  end

endmodule : mux_select_bank

// File: tb/tb_mux_select_bank.sv
// Self-checking bench for mux_select_bank: directed scenarios plus
// randomized stimulus against an array-indexed reference model.
module tb_mux_select_bank;

  localparam int BUS_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_a, i_b, select;
  logic             o_data, o_data_q;
  logic             a, b, c, d;
  logic [1:0]       sel4;
  logic             out4, out4_q;
  logic [BUS_W-1:0] bus_a, bus_b, bus_c, bus_d;
  logic [1:0]       bus_sel;
  logic [BUS_W-1:0] bus_out, bus_out_q;

  int n_checks = 0;
  int n_errors = 0;

  // Expected registered values, captured by the model at each clock edge.
  logic             exp_data_q;
  logic             exp_out4_q;
  logic [BUS_W-1:0] exp_bus_q;

  mux_select_bank #(.BUS_W(BUS_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_a       (i_a),
    .i_b       (i_b),
    .select    (select),
    .o_data    (o_data),
    .o_data_q  (o_data_q),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .sel4      (sel4),
    .out4      (out4),
    .out4_q    (out4_q),
    .bus_a     (bus_a),
    .bus_b     (bus_b),
    .bus_c     (bus_c),
    .bus_d     (bus_d),
    .bus_sel   (bus_sel),
    .bus_out   (bus_out),
    .bus_out_q (bus_out_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: pick by index from an array of the candidate inputs.
  function automatic logic ref_2to1();
    logic pair [2];
    pair[0] = i_a;
    pair[1] = i_b;
    return pair[select];
  endfunction

  function automatic logic ref_bit4();
    logic bits [4];
    bits = '{a, b, c, d};
    return bits[sel4];
  endfunction

  function automatic logic [BUS_W-1:0] ref_bus4();
    logic [BUS_W-1:0] words [4];
    words = '{bus_a, bus_b, bus_c, bus_d};
    return words[bus_sel];
  endfunction

  task automatic check_comb(input string tag);
    check({tag, ".o_data"},  64'(o_data),  64'(ref_2to1()));
    check({tag, ".out4"},    64'(out4),    64'(ref_bit4()));
    check({tag, ".bus_out"}, 64'(bus_out), 64'(ref_bus4()));
  endtask

  // Advance one clock edge: model captures pre-edge results, then sample.
  task automatic tick_and_check(input string tag);
    @(posedge clk);
    if (rst) begin
      exp_data_q = 1'b0; exp_out4_q = 1'b0; exp_bus_q = '0;
    end else begin
      exp_data_q = ref_2to1(); exp_out4_q = ref_bit4(); exp_bus_q = ref_bus4();
    end
    #1;
    check({tag, ".o_data_q"},  64'(o_data_q),  64'(exp_data_q));
    check({tag, ".out4_q"},    64'(out4_q),    64'(exp_out4_q));
    check({tag, ".bus_out_q"}, 64'(bus_out_q), 64'(exp_bus_q));
  endtask

  task automatic randomize_inputs();
    i_a = 1'($urandom); i_b = 1'($urandom); select = 1'($urandom);
    a = 1'($urandom); b = 1'($urandom); c = 1'($urandom); d = 1'($urandom);
    sel4 = 2'($urandom);
    bus_a = BUS_W'($urandom); bus_b = BUS_W'($urandom);
    bus_c = BUS_W'($urandom); bus_d = BUS_W'($urandom);
    bus_sel = 2'($urandom);
  endtask

  initial begin
    logic             held_out4;
    logic [BUS_W-1:0] held_bus;
    logic [3:0]       walk;

    rst = 1'b1;
    i_a = 0; i_b = 0; select = 0;
    a = 0; b = 0; c = 0; d = 0; sel4 = 2'b00;
    bus_a = '0; bus_b = '0; bus_c = '0; bus_d = '0; bus_sel = 2'b00;

    // Reset state, with combinational outputs still following inputs.
    #2;
    check("rst.o_data_q",  64'(o_data_q),  64'd0);
    check("rst.out4_q",    64'(out4_q),    64'd0);
    check("rst.bus_out_q", 64'(bus_out_q), 64'd0);
    bus_a = 8'h5a; i_a = 1'b1; a = 1'b1;
    #1;
    check_comb("rst_follow");
    tick_and_check("rst_hold");
    @(negedge clk);
    rst = 1'b0;

    // 2:1 mux directed sequence.
    i_a = 1'b0; i_b = 1'b1; select = 1'b0;
    #1;
    check("dir2.sel0.o_data", 64'(o_data), 64'd0);
    tick_and_check("dir2.sel0");
    select = 1'b1;
    #1;
    check("dir2.sel1.o_data", 64'(o_data), 64'd1);
    check("dir2.sel1.q_stale", 64'(o_data_q), 64'd0);
    tick_and_check("dir2.sel1");

    // 4:1 bit mux: b=1 with sel4=01, then walk a single 1 for every select.
    a = 0; b = 1; c = 0; d = 0; sel4 = 2'b01;
    #1;
    check("dir4.b_sel01", 64'(out4), 64'd1);
    for (int s = 0; s < 4; s++) begin
      for (int w = 0; w < 4; w++) begin
        walk = 4'b0001 << w;
        {d, c, b, a} = walk;
        sel4 = 2'(s);
        #1;
        check($sformatf("walk.s%0d.w%0d", s, w), 64'(out4), 64'(s == w));
      end
    end

    // Bus mux: each select with its own distinct word, registered copy next edge.
    bus_a = 8'h01; bus_b = 8'h02; bus_c = 8'h03; bus_d = 8'h04;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      bus_sel = 2'(s);
      #1;
      check($sformatf("bus.sel%0d", s), 64'(bus_out), 64'(s + 1));
      tick_and_check($sformatf("bus.sel%0d", s));
    end

    // Asynchronous reset mid-cycle while bus_out_q holds 8'h04.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst.bus_out_q", 64'(bus_out_q), 64'h00);
    check("async_rst.bus_out",   64'(bus_out),   64'h04);
    tick_and_check("rst_held");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_release.pre_edge", 64'(bus_out_q), 64'h00);
    tick_and_check("rst_release");
    check("rst_release.bus_q", 64'(bus_out_q), 64'h04);

    // Unknown select drives zero (only meaningful on a four-state simulator).
    @(negedge clk);
    bus_sel = 2'bxx;
    #1;
    if ($isunknown(bus_sel))
      check("bus_sel_x", 64'(bus_out), 64'h00);
    bus_sel = 2'b11;

    // Independence: toggling select alone leaves the other muxes alone.
    randomize_inputs();
    #1;
    held_out4 = out4;
    held_bus  = bus_out;
    select = ~select;
    #1;
    check("indep.out4",    64'(out4),    64'(held_out4));
    check("indep.bus_out", 64'(bus_out), 64'(held_bus));
    check_comb("indep");

    // Randomized stimulus, including between-edge changes.
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      randomize_inputs();
      #1;
      check_comb($sformatf("rnd%0d", i));
      tick_and_check($sformatf("rnd%0d", i));
      // Change inputs just after the edge: registered outputs must hold.
      randomize_inputs();
      #1;
      check_comb($sformatf("rnd%0d.mid", i));
      check($sformatf("rnd%0d.mid.bus_q", i), 64'(bus_out_q), 64'(exp_bus_q));
      check($sformatf("rnd%0d.mid.out4_q", i), 64'(out4_q), 64'(exp_out4_q));
      check($sformatf("rnd%0d.mid.data_q", i), 64'(o_data_q), 64'(exp_data_q));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_mux_select_bank
